// File: rtl/demux15_varredura_if.sv
// Signal bundle between the 15-column scan engine and the 15-input mux/readout side.
// The master side is the scan engine; the slave side feeds habilita/entrada and consumes the frame.
interface demux15_varredura_if;
  logic        habilita;
  logic        entrada;
  logic [3:0]  seletor;
  logic        amostra;
  logic [14:0] saidas;
  logic        quadro_pronto;

  modport master (
    input  habilita,
    input  entrada,
    output seletor,
    output amostra,
    output saidas,
    output quadro_pronto
  );

  modport slave (
    output habilita,
    output entrada,
    input  seletor,
    input  amostra,
    input  saidas,
    input  quadro_pronto
  );
endinterface

// File: rtl/demux15_varredura.sv
// Scan engine for a 15-input mux: steps the selector through slots 1..15, captures the returned
// bit at the end of each slot into a shadow register and publishes whole frames on saidas.
module demux15_varredura #(
  parameter int unsigned DIVISOR = 4  // clocks per selector slot, 2..65535
) (
  input logic                   clock,
  input logic                   reset,
  demux15_varredura_if.master   bus
);

  localparam int unsigned           DIV_W    = $clog2(DIVISOR);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIVISOR - 1);

  typedef enum logic {OCIOSO, VARRE} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        sel_q, sel_d;
  logic [14:0]       shadow_q, shadow_d;
  logic [14:0]       saidas_q, saidas_d;
  logic              pronto_q, pronto_d;
  logic              ultimo_ciclo;

  assign ultimo_ciclo      = (state_q == VARRE) && (div_q == DIV_LAST);
  assign bus.amostra       = ultimo_ciclo;
  assign bus.seletor       = sel_q;
  assign bus.saidas        = saidas_q;
  assign bus.quadro_pronto = pronto_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    div_d    = div_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    saidas_d = saidas_q;
    pronto_d = 1'b0;

    unique case (state_q)
      OCIOSO: begin
        div_d = '0;
        sel_d = 4'd1;
        if (bus.habilita) state_d = VARRE;
      end

      VARRE: begin
        // Dropping habilita wins over a capture, even on the frame-completing edge.
        if (!bus.habilita) begin
          state_d  = OCIOSO;
          div_d    = '0;
          sel_d    = 4'd1;
          shadow_d = '0;
        end else if (div_q == DIV_LAST) begin
          div_d                    = '0;
          shadow_d[sel_q - 4'd1]   = bus.entrada;
          if (sel_q == 4'd15) begin
            sel_d    = 4'd1;
            saidas_d = {bus.entrada, shadow_q[13:0]};
            pronto_d = 1'b1;
            shadow_d = '0;
          end else begin
            sel_d = sel_q + 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      div_q    <= '0;
      sel_q    <= 4'd1;
      // NOTE: the shadow is reset too; a stale partial frame must never leak into the next one.
      shadow_q <= '0;
      saidas_q <= '0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      saidas_q <= saidas_d;
      pronto_q <= pronto_d;
    end
  end

endmodule

// File: doc/demux15_varredura.md
# demux15_varredura

Scan engine for the 15-column display/input path. Drives the 4-bit selector that a 15-input mux uses to pick one bit. Captures the bit returned by the mux on each slot into a shadow register, and publishes the complete 15-bit frame in parallel once per scan. It is the return path of the mux: selector generator and serial-to-parallel collector.

## Interface
Parameters:
- DIVISOR, default 4: clocks per selector slot; legal range 2..65535.

Ports:
- clock  input  1: rising-edge clock, the only clock.
- reset  input  1: asynchronous, active-high reset.
- habilita  input  1: scan enable; level-sensitive.
- entrada  input  1: bit returned by the 15-input mux for the current seletor.
- seletor  output  4: registered; current slot, 1..15; value 0 is never driven.
- amostra  output  1: high during the last clock of each slot, when entrada is captured.
- saidas  output  15: registered; last complete frame; bit k-1 holds the value captured at seletor=k.
- quadro_pronto  output  1: registered one-cycle pulse when saidas is updated.

## Operation
- Reset values:
  - seletor=1, saidas=0, quadro_pronto=0, amostra=0.
  - Internal state: state=OCIOSO, slot counter div=0, shadow register=0.
- The FSM has two states, OCIOSO and VARRE.
- OCIOSO:
  - seletor is held at 1, div=0, amostra=0.
  - On a clock edge with habilita=1, the FSM moves to VARRE with div=0 and seletor=1.
- VARRE, div behaviour:
  - div counts 0..DIVISOR-1 and wraps.
  - amostra = (state==VARRE && div==DIVISOR-1). It is decoded combinationally from registered state.
- VARRE, on an edge where div==DIVISOR-1:
  - shadow[seletor-1] <= entrada.
  - If seletor<15: seletor increments.
  - If seletor==15: seletor <= 1, saidas <= shadow with bit 14 replaced by the current entrada, and quadro_pronto <= 1. The shadow register is cleared.
- quadro_pronto is 1 for exactly one cycle per completed frame; otherwise 0.
- Scanning runs continuously while habilita=1. Frames follow back-to-back with no gap cycle.
- habilita=0 in VARRE (abort), at the next edge:
  - State returns to OCIOSO; seletor=1, div=0, shadow cleared.
  - saidas is unchanged and quadro_pronto stays 0, even if that edge would have completed the frame.
  - The abort has priority over capture.
- saidas only ever changes on frame completion or reset. Partial frames are never visible.
- entrada is sampled only on amostra cycles. Its value at any other time is ignored.

## Timing
- Let E0 be the edge on which habilita=1 is seen in OCIOSO.
  - Slot k occupies the cycles after edges E0+(k-1)·DIVISOR .. E0+k·DIVISOR-1.
  - Capture for slot k happens on edge E0+k·DIVISOR.
- Frame length is 15·DIVISOR clocks.
  - saidas and quadro_pronto update on edge E0+15·DIVISOR, and the two are coincident.
  - seletor=1 is visible from that same edge.
- Latency from entrada at the last slot to visibility on saidas is 1 clock.
- Asynchronous reset mid-frame:
  - All outputs and state go to their reset values immediately, without waiting for a clock.
  - After reset release, scanning resumes only via OCIOSO → VARRE, i.e. on the first edge with habilita=1.
- div and seletor never take out-of-range values. There is no wrap through 0.

## Test plan
- Reset (DIVISOR=4): assert reset asynchronously between edges → seletor=1, saidas=15'h0000, quadro_pronto=0, amostra=0 immediately.
- Single frame:
  - Stimulus: habilita=1; drive entrada = P[seletor-1] with P=15'h5A3C.
  - Response: seletor steps 1,2,…,15 every 4 clocks; amostra high 1 of every 4 cycles; after 60 clocks saidas=15'h5A3C and quadro_pronto high for exactly 1 cycle.
- Back-to-back frames:
  - Stimulus: keep habilita=1; second frame with P=15'h7FFF.
  - Response: saidas holds 15'h5A3C for the full 60 clocks, then becomes 15'h7FFF; seletor never reads 0 or 16.
- Abort:
  - Stimulus: drop habilita during slot 7 of a frame.
  - Response: next edge gives seletor=1, amostra=0, no quadro_pronto, saidas unchanged. Re-raising habilita yields a full 60-clock frame starting at slot 1.
- Abort on the completing edge: habilita=0 sampled on the edge where seletor=15 and div=3 → saidas unchanged, quadro_pronto stays 0.
- Sampling point: toggle entrada in the non-amostra cycles of each slot, holding the target bit only on the amostra cycle → captured frame equals the amostra-cycle values only.
